// File: rtl/ex_stage_unit_if.sv
// ex_stage_unit_if - signal bundle between the decode/execute pipeline register
// and the execute stage. The master side is whatever drives the decoded
// instruction fields; the slave side is the execute stage itself.
interface ex_stage_unit_if;

    // Decoded instruction fields
    logic        valid;
    logic [15:0] reg1;
    logic [15:0] reg2;
    logic [15:0] imm;
    logic        alu_src;
    logic [3:0]  alu_op;
    logic        set_c;
    logic        clr_c;
    logic        branch;
    logic [1:0]  cond;
    logic [1:0]  stack_op;

    // Execute results toward the execute/memory buffer and fetch
    logic [15:0] result;
    logic [2:0]  flags;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        flush;
    logic [15:0] stack_addr;
    logic [15:0] sp;
    logic        stack_err;

    modport master (
        output valid, reg1, reg2, imm, alu_src, alu_op,
               set_c, clr_c, branch, cond, stack_op,
        input  result, flags, branch_taken, branch_target,
               flush, stack_addr, sp, stack_err
    );

    modport slave (
        input  valid, reg1, reg2, imm, alu_src, alu_op,
               set_c, clr_c, branch, cond, stack_op,
        output result, flags, branch_taken, branch_target,
               flush, stack_addr, sp, stack_err
    );

endinterface

// File: rtl/ex_stage_unit.sv
// ex_stage_unit - execute stage of the pipeline.
// Computes the ALU result, owns the {C,N,Z} condition flags and the stack
// pointer, resolves conditional branches and drives the flush window that
// squashes the younger, wrongly fetched instructions.
// Optional feature: define STACK_GUARD_EN to block stack overflow/underflow
// and raise a sticky stack error; without it the stack pointer wraps freely.
module ex_stage_unit #(
    parameter logic [15:0] SP_RESET     = 16'h07FF,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    ex_stage_unit_if.slave bus
);

    // ALU opcodes
    localparam logic [3:0] OP_PASSA = 4'd0;
    localparam logic [3:0] OP_NOT   = 4'd1;
    localparam logic [3:0] OP_INC   = 4'd2;
    localparam logic [3:0] OP_DEC   = 4'd3;
    localparam logic [3:0] OP_ADD   = 4'd4;
    localparam logic [3:0] OP_SUB   = 4'd5;
    localparam logic [3:0] OP_AND   = 4'd6;
    localparam logic [3:0] OP_OR    = 4'd7;
    localparam logic [3:0] OP_SHL   = 4'd8;
    localparam logic [3:0] OP_SHR   = 4'd9;

    // Branch conditions
    localparam logic [1:0] COND_JMP = 2'b00;
    localparam logic [1:0] COND_JZ  = 2'b01;
    localparam logic [1:0] COND_JN  = 2'b10;
    localparam logic [1:0] COND_JC  = 2'b11;

    // Stack operations (2'b11 behaves like no operation)
    localparam logic [1:0] STK_PUSH = 2'b01;
    localparam logic [1:0] STK_POP  = 2'b10;

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

    // Architectural state
    logic        cf;
    logic        nf;
    logic        zf;
    logic [15:0] sp_q;
    logic [1:0]  flush_cnt;
    logic        stack_err_q;

    // Combinational helpers
    logic        v;
    logic [15:0] opa;
    logic [15:0] opb;
    logic [3:0]  shamt;
    logic [15:0] alu_result;
    logic [16:0] wide;
    logic        alu_c;
    logic        upd_zn;
    logic        upd_c;
    logic        cond_met;
    logic        taken;
    logic        next_c;
    logic        next_n;
    logic        next_z;
    logic        is_push;
    logic        is_pop;
    logic        push_err;
    logic        pop_err;
    logic [15:0] sp_inc;
    logic [15:0] sp_dec;

    // An instruction is only real when it is not a bubble and not squashed
    assign v     = bus.valid & (flush_cnt == 2'd0);
    assign opa   = bus.reg1;
    assign opb   = bus.alu_src ? bus.imm : bus.reg2;
    assign shamt = opb[3:0];

    // ALU datapath; the 17-bit wide value carries the carry/borrow/shifted-out bit
    always_comb begin
        alu_result = opb;
        alu_c      = cf;
        upd_zn     = 1'b0;
        upd_c      = 1'b0;
        wide       = 17'd0;
        case (bus.alu_op)
            OP_PASSA: begin
                alu_result = opa;
            end
            OP_NOT: begin
                alu_result = ~opa;
                upd_zn     = 1'b1;
            end
            OP_INC: begin
                wide       = {1'b0, opa} + 17'd1;
                alu_result = wide[15:0];
                alu_c      = wide[16];
                upd_zn     = 1'b1;
                upd_c      = 1'b1;
            end
            OP_DEC: begin
                wide       = {1'b0, opa} - 17'd1;
                alu_result = wide[15:0];
                alu_c      = wide[16];
                upd_zn     = 1'b1;
                upd_c      = 1'b1;
            end
            OP_ADD: begin
                wide       = {1'b0, opa} + {1'b0, opb};
                alu_result = wide[15:0];
                alu_c      = wide[16];
                upd_zn     = 1'b1;
                upd_c      = 1'b1;
            end
            OP_SUB: begin
                wide       = {1'b0, opa} - {1'b0, opb};
                alu_result = wide[15:0];
                alu_c      = wide[16];
                upd_zn     = 1'b1;
                upd_c      = 1'b1;
            end
            OP_AND: begin
                alu_result = opa & opb;
                upd_zn     = 1'b1;
            end
            OP_OR: begin
                alu_result = opa | opb;
                upd_zn     = 1'b1;
            end
            OP_SHL: begin
                wide       = {1'b0, opa} << shamt;
                alu_result = wide[15:0];
                alu_c      = wide[16];
                upd_zn     = 1'b1;
                upd_c      = (shamt != 4'd0);
            end
            OP_SHR: begin
                wide       = {opa, 1'b0} >> shamt;
                alu_result = wide[16:1];
                alu_c      = wide[0];
                upd_zn     = 1'b1;
                upd_c      = (shamt != 4'd0);
            end
            default: begin
                alu_result = opb;
            end
        endcase
    end

    // Branch resolution against the flags as they stand before this edge
    always_comb begin
        cond_met = 1'b0;
        case (bus.cond)
            COND_JMP: cond_met = 1'b1;
            COND_JZ:  cond_met = zf;
            COND_JN:  cond_met = nf;
            COND_JC:  cond_met = cf;
            default:  cond_met = 1'b0;
        endcase
        taken = v & bus.branch & cond_met;
    end

    // Next flag values: ALU update, then carry control, then the branch clear
    always_comb begin
        next_c = cf;
        next_n = nf;
        next_z = zf;
        if (upd_zn) begin
            next_z = (alu_result == 16'd0);
            next_n = alu_result[15];
        end
        if (upd_c) begin
            next_c = alu_c;
        end
        if (bus.set_c) begin
            next_c = 1'b1;
        end else if (bus.clr_c) begin
            next_c = 1'b0;
        end
        if (taken) begin
            case (bus.cond)
                COND_JZ: next_z = 1'b0;
                COND_JN: next_n = 1'b0;
                COND_JC: next_c = 1'b0;
                default: ;
            endcase
        end
    end

    // Stack address and overflow/underflow detection
    always_comb begin
        is_push    = v & (bus.stack_op == STK_PUSH);
        is_pop     = v & (bus.stack_op == STK_POP);
        sp_inc     = sp_q + 16'd1;
        sp_dec     = sp_q - 16'd1;
        push_err   = is_push & (sp_q == 16'h0000);
        pop_err    = is_pop & (sp_q == SP_RESET);
    end

    // Condition flags only move for real instructions
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cf <= 1'b0;
            nf <= 1'b0;
            zf <= 1'b0;
        end else if (v) begin
            cf <= next_c;
            nf <= next_n;
            zf <= next_z;
        end
    end

    // Flush window: load on a taken branch, otherwise count down to idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt <= 2'd0;
        end else if (taken) begin
            flush_cnt <= FLUSH_LOAD;
        end else if (flush_cnt != 2'd0) begin
            flush_cnt <= flush_cnt - 2'd1;
        end
    end

`ifdef STACK_GUARD_EN
    // Guarded stack pointer: an overflowing push or underflowing pop is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= SP_RESET;
        end else if (is_push && !push_err) begin
            sp_q <= sp_dec;
        end else if (is_pop && !pop_err) begin
            sp_q <= sp_inc;
        end
    end

    // Sticky stack error, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stack_err_q <= 1'b0;
        end else if (push_err || pop_err) begin
            stack_err_q <= 1'b1;
        end
    end
`else
    // Free-running stack pointer, wrapping modulo 2^16
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= SP_RESET;
        end else if (is_push) begin
            sp_q <= sp_dec;
        end else if (is_pop) begin
            sp_q <= sp_inc;
        end
    end

    // The error only exists with the guard; keep the error logic quiet here
    always_comb begin
        stack_err_q = 1'b0 & (push_err | pop_err);
    end
`endif

    assign bus.result        = alu_result;
    assign bus.flags         = {cf, nf, zf};
    assign bus.branch_taken  = taken;
    assign bus.branch_target = bus.reg1;
    assign bus.flush         = (flush_cnt != 2'd0);
    assign bus.stack_addr    = is_pop ? sp_inc : sp_q;
    assign bus.sp            = sp_q;
    assign bus.stack_err     = stack_err_q;

endmodule

// File: tb/tb_ex_stage_unit.sv
// tb_ex_stage_unit - directed and randomized bench for ex_stage_unit.
// A behavioural model of the execute stage predicts every output each cycle.
module tb_ex_stage_unit;

    localparam logic [15:0] SP_RST  = 16'h07FF;
    localparam int          FLUSH_N = 2;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    // Behavioural model state
    bit          mC;
    bit          mN;
    bit          mZ;
    int unsigned mSp;
    int          mFlushLeft;
    bit          mErr;

    ex_stage_unit_if bus();

    ex_stage_unit #(
        .SP_RESET    (SP_RST),
        .FLUSH_CYCLES(FLUSH_N)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned opB();
        return bus.alu_src ? 32'(bus.imm) : 32'(bus.reg2);
    endfunction

    function automatic int unsigned modelResult();
        int unsigned a;
        int unsigned b;
        int unsigned n;
        a = bus.reg1;
        b = opB();
        n = b % 16;
        case (int'(bus.alu_op))
            0:       return a;
            1:       return (~a) & 32'hFFFF;
            2:       return (a + 1) & 32'hFFFF;
            3:       return (a - 1) & 32'hFFFF;
            4:       return (a + b) & 32'hFFFF;
            5:       return (a - b) & 32'hFFFF;
            6:       return a & b;
            7:       return a | b;
            8:       return (a << n) & 32'hFFFF;
            9:       return a >> n;
            default: return b;
        endcase
    endfunction

    function automatic bit modelValid();
        return bus.valid && (mFlushLeft == 0);
    endfunction

    function automatic bit modelTaken();
        bit met;
        case (int'(bus.cond))
            0:       met = 1'b1;
            1:       met = mZ;
            2:       met = mN;
            default: met = mC;
        endcase
        return modelValid() && bus.branch && met;
    endfunction

    function automatic int unsigned modelAddr();
        if (modelValid() && bus.stack_op == 2'b10) return (mSp + 1) % 65536;
        return mSp;
    endfunction

    task automatic modelReset();
        mC = 0; mN = 0; mZ = 0;
        mSp = SP_RST;
        mFlushLeft = 0;
        mErr = 0;
    endtask

    // Advance the model by one clock edge using the inputs the DUT just sampled
    task automatic modelStep();
        int unsigned a;
        int unsigned b;
        int unsigned n;
        int unsigned res;
        bit          tk;
        bit          v;
        int          op;
        v   = modelValid();
        tk  = modelTaken();
        a   = bus.reg1;
        b   = opB();
        n   = b % 16;
        res = modelResult();
        op  = int'(bus.alu_op);
        if (v) begin
            if (op >= 1 && op <= 9) begin
                mZ = (res == 0);
                mN = (res >= 32768);
            end
            case (op)
                2: mC = (a == 32'hFFFF);
                3: mC = (a == 0);
                4: mC = (a + b) > 32'hFFFF;
                5: mC = (a < b);
                8: if (n != 0) mC = ((a >> (16 - n)) & 1) == 1;
                9: if (n != 0) mC = ((a >> (n - 1)) & 1) == 1;
                default: ;
            endcase
            if (bus.set_c) mC = 1;
            else if (bus.clr_c) mC = 0;
            if (tk) begin
                if (bus.cond == 2'b01) mZ = 0;
                if (bus.cond == 2'b10) mN = 0;
                if (bus.cond == 2'b11) mC = 0;
            end
            if (bus.stack_op == 2'b01) begin
`ifdef STACK_GUARD_EN
                if (mSp == 0) mErr = 1;
                else mSp = mSp - 1;
`else
                mSp = (mSp + 65535) % 65536;
`endif
            end else if (bus.stack_op == 2'b10) begin
`ifdef STACK_GUARD_EN
                if (mSp == SP_RST) mErr = 1;
                else mSp = mSp + 1;
`else
                mSp = (mSp + 1) % 65536;
`endif
            end
        end
        if (tk) mFlushLeft = FLUSH_N;
        else if (mFlushLeft > 0) mFlushLeft--;
    endtask

    // Compare every DUT output against the model for the current cycle
    task automatic checkOutput();
        checkVal("result",    32'(bus.result),        modelResult());
        checkVal("flags",     32'(bus.flags),         32'({mC, mN, mZ}));
        checkVal("taken",     32'(bus.branch_taken),  32'(modelTaken()));
        checkVal("target",    32'(bus.branch_target), 32'(bus.reg1));
        checkVal("flush",     32'(bus.flush),         32'(mFlushLeft != 0));
        checkVal("stackaddr", 32'(bus.stack_addr),    modelAddr());
        checkVal("sp",        32'(bus.sp),            mSp);
        checkVal("stackerr",  32'(bus.stack_err),     32'(mErr));
    endtask

    task automatic applyStimulus(input bit valid, input logic [15:0] r1, input logic [15:0] r2,
                                 input logic [15:0] imm, input bit src, input logic [3:0] op,
                                 input bit setc, input bit clrc, input bit br,
                                 input logic [1:0] cond, input logic [1:0] sop);
        bus.valid    = valid;
        bus.reg1     = r1;
        bus.reg2     = r2;
        bus.imm      = imm;
        bus.alu_src  = src;
        bus.alu_op   = op;
        bus.set_c    = setc;
        bus.clr_c    = clrc;
        bus.branch   = br;
        bus.cond     = cond;
        bus.stack_op = sop;
        #1;
    endtask

    function automatic logic [15:0] randWord();
        case ($urandom_range(0, 4))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'($urandom_range(0, 8));
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic randomStimulus();
        applyStimulus($urandom_range(0, 7) != 0, randWord(), randWord(), randWord(),
                      1'($urandom), 4'($urandom),
                      $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 4) == 0, 2'($urandom), 2'($urandom));
    endtask

    task automatic runCycle();
        checkOutput();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        #2;
        modelReset();
        rst = 1'b0;
        #1;
    endtask

    // Directed scenarios with literal expectations, then randomized traffic
    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        modelReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        checkVal("rst_flags", 32'(bus.flags), 32'h0);
        checkVal("rst_sp",    32'(bus.sp),    32'h07FF);
        checkVal("rst_flush", 32'(bus.flush), 32'h0);
        checkVal("rst_err",   32'(bus.stack_err), 32'h0);
        rst = 1'b0;

        // ADD FFFF + 0001 -> 0 with carry and zero
        applyStimulus(1, 16'hFFFF, 16'h0001, 16'h1234, 0, 4'd4, 0, 0, 0, 0, 0);
        checkVal("add_result", 32'(bus.result), 32'h0);
        runCycle();
        checkVal("add_flags", 32'(bus.flags), 32'b101);

        // JZ taken, Z cleared, two-cycle flush that swallows a JMP
        applyStimulus(1, 16'h0040, 0, 0, 0, 4'd0, 0, 0, 1, 2'b01, 0);
        checkVal("jz_taken",  32'(bus.branch_taken), 32'h1);
        checkVal("jz_target", 32'(bus.branch_target), 32'h0040);
        runCycle();
        checkVal("jz_flags",  32'(bus.flags), 32'b100);
        checkVal("flush_c1",  32'(bus.flush), 32'h1);
        applyStimulus(1, 16'h0080, 0, 0, 0, 4'd0, 0, 0, 1, 2'b00, 0);
        checkVal("jmp_squash", 32'(bus.branch_taken), 32'h0);
        runCycle();
        checkVal("flush_c2",  32'(bus.flush), 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0);
        runCycle();
        checkVal("flush_end", 32'(bus.flush), 32'h0);

        // Push, push, pop from reset
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 2'b01);
        checkVal("push1_addr", 32'(bus.stack_addr), 32'h07FF);
        runCycle();
        applyStimulus(1, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 2'b01);
        checkVal("push2_addr", 32'(bus.stack_addr), 32'h07FE);
        runCycle();
        checkVal("push2_sp",   32'(bus.sp), 32'h07FD);
        applyStimulus(1, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 2'b10);
        checkVal("pop_addr",   32'(bus.stack_addr), 32'h07FE);
        runCycle();
        checkVal("pop_sp",     32'(bus.sp), 32'h07FE);

        // Carry control: clear alone, then set beats clear
        applyStimulus(1, 16'd3, 16'd3, 0, 0, 4'd5, 0, 1, 0, 0, 0);
        runCycle();
        checkVal("clrc_flags", 32'(bus.flags), 32'b001);
        applyStimulus(1, 16'd5, 16'd3, 0, 0, 4'd5, 1, 1, 0, 0, 0);
        checkVal("sub_result", 32'(bus.result), 32'h2);
        runCycle();
        checkVal("setc_flags", 32'(bus.flags), 32'b100);

        // Asynchronous reset in the middle of a flush window
        applyStimulus(1, 16'h0100, 0, 0, 0, 4'd0, 0, 0, 1, 2'b00, 2'b01);
        runCycle();
        checkVal("pre_rst_flush", 32'(bus.flush), 32'h1);
        checkVal("pre_rst_sp",    32'(bus.sp), 32'h07FD);
        rst = 1'b1;
        #1;
        checkVal("async_flush", 32'(bus.flush), 32'h0);
        checkVal("async_sp",    32'(bus.sp), 32'h07FF);
        modelReset();
        rst = 1'b0;
        #1;
        applyStimulus(1, 16'h0200, 0, 0, 0, 4'd0, 0, 0, 1, 2'b00, 0);
        checkVal("post_rst_taken", 32'(bus.branch_taken), 32'h1);
        runCycle();

        // Pop at the top of the stack
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 2'b10);
        checkVal("top_pop_addr", 32'(bus.stack_addr), 32'h0800);
        runCycle();
`ifdef STACK_GUARD_EN
        checkVal("top_pop_sp",  32'(bus.sp), 32'h07FF);
        checkVal("top_pop_err", 32'(bus.stack_err), 32'h1);
`else
        checkVal("top_pop_sp",  32'(bus.sp), 32'h0800);
        checkVal("top_pop_err", 32'(bus.stack_err), 32'h0);
`endif
        applyStimulus(0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0);
        runCycle();

        // Randomized traffic with occasional asynchronous resets
        doReset();
        for (int i = 0; i < 800; i++) begin
            randomStimulus();
            runCycle();
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                #1;
                modelReset();
                checkOutput();
                rst = 1'b0;
                #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_stage_unit.md
Name: ex_stage_unit

Overview:
- Execute-stage consumer of the decode/execute pipeline register fields.
- Computes the ALU result and owns the architectural CCR flags (Z, N, C).
- Owns the stack pointer, which is updated by push/pop.
- Resolves conditional branches and drives the flush count that squashes the wrongly fetched younger instructions.
- Outputs feed the execute/memory buffer and the fetch unit.

Parameters:
SP_RESET, 16'h07FF, stack pointer value after reset (top of data memory)
FLUSH_CYCLES, 2, number of cycles FlushOut stays high after a taken branch (1..3)

Ports:
Clk  in  1  clock, state updates on posedge
Rst  in  1  asynchronous active-high reset
ValidIn  in  1  instruction in execute is real (0 = bubble)
Reg1In  in  16  source operand 1 / branch target
Reg2In  in  16  source operand 2
ImmIn  in  16  immediate (instruction word)
ALU_srcIn  in  1  1 = operand B is ImmIn, 0 = Reg2In
aluSignalsIn  in  4  ALU opcode
SetCIn  in  1  set carry
CLRCIn  in  1  clear carry
BranchIn  in  1  instruction is a branch
CondIn  in  2  00 JMP, 01 JZ, 10 JN, 11 JC
StackOpIn  in  2  00 none, 01 push, 10 pop, 11 none
ResultOut  out  16  combinational ALU result
FlagsOut  out  3  registered {C,N,Z}
BranchTakenOut  out  1  combinational taken decision
BranchTargetOut  out  16  equals Reg1In
FlushOut  out  1  registered, high while younger stages are squashed
StackAddrOut  out  16  combinational memory address for push/pop
SpOut  out  16  registered stack pointer
StackErrOut  out  1  sticky stack error (see Optional Feature)

Behaviour:
- Reset (async, Rst=1): FlagsOut=3'b000, SpOut=SP_RESET, FlushOut=0, internal flush counter=0, StackErrOut=0.
- Effective valid: v = ValidIn & ~FlushOut. If v=0, no flag/SP/counter update except counter decrement. BranchTakenOut=0 and StackAddrOut=SpOut in that case.
- ALU (B = ALU_srcIn ? ImmIn : Reg2In), 16-bit modulo:
  - 0 pass A
  - 1 NOT A
  - 2 A+1
  - 3 A-1
  - 4 A+B
  - 5 A-B
  - 6 A&B
  - 7 A|B
  - 8 A<<B[3:0]
  - 9 A>>B[3:0] logical
  - 10-15 pass B
- Flags, updated on posedge when v:
  - Ops 2-5 update Z, N and C. C is the carry-out (add/inc) or the borrow (sub/dec).
  - Ops 1 and 6-9 update Z and N only. Shifts set C to the last bit shifted out; a shift amount of 0 leaves C unchanged.
  - Ops 0 and 10-15 leave all flags unchanged.
- Carry control: SetCIn forces C=1 and CLRCIn forces C=0. Both override the ALU carry. If both are high, SetCIn wins.
- Branch: taken = v & BranchIn & (JMP | (JZ&Z) | (JN&N) | (JC&C)).
  - A taken conditional branch clears the flag it tested on the same edge. The clear has priority over any ALU update.
- Flush: on a taken branch the counter loads FLUSH_CYCLES at the posedge. FlushOut = (counter != 0). The counter decrements each cycle down to 0.
  - Branches arriving while FlushOut=1 are squashed, not evaluated.
- Stack:
  - Push: StackAddrOut=SpOut; SP <= SpOut-1.
  - Pop: StackAddrOut=SpOut+1; SP <= SpOut+1.
  - Updates only when v. SP arithmetic is modulo 2^16.
- Reset mid-flush returns the block to idle immediately; the first instruction after reset release is evaluated normally.

Optional Feature:
- Macro: STACK_GUARD_EN.
- Defined:
  - A push with SpOut==16'h0000 or a pop with SpOut==SP_RESET is an error.
  - On error: SP is not updated, StackErrOut goes to 1 and stays there until reset, and StackAddrOut still shows the computed address.
- Undefined: SP wraps freely and StackErrOut is tied 0.

Test Plan:
- Reset, then ADD Reg1In=16'hFFFF, Reg2In=16'h0001, ALU_srcIn=0, v=1 -> ResultOut=0; next cycle FlagsOut={C=1,N=0,Z=1}.
- Z=1, then BranchIn=1, CondIn=01, Reg1In=16'h0040 -> BranchTakenOut=1 and BranchTargetOut=16'h0040 same cycle; Z=0 after the edge; FlushOut=1 for exactly 2 cycles; a JMP in those cycles is ignored.
- Push twice from reset -> StackAddrOut 07FF then 07FE, SpOut=07FD; one pop -> StackAddrOut=07FE, SpOut=07FE.
- SetCIn=1 and CLRCIn=1 together with SUB 5-3 -> C=1, Z=0, N=0.
- Assert Rst while FlushOut=1 -> FlushOut=0 and SpOut=07FF immediately, with no clock edge needed.
- With STACK_GUARD_EN, pop at SpOut=07FF -> SpOut stays 07FF and StackErrOut=1 until Rst.
